// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_op_signed;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic             w_iter_start;
    logic             w_fast_wr;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_accept    = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_is_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_is_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_op_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_rs_neg    = w_op_signed && i_rs[WIDTH-1];
    assign w_rt_neg    = w_op_signed && i_rt[WIDTH-1];
    assign w_rs_mag    = w_rs_neg ? -i_rs : i_rs;
    assign w_rt_mag    = w_rt_neg ? -i_rt : i_rt;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_a;
    logic [2*WIDTH-1:0] w_fast_b;
    // Extending to 2*WIDTH first makes a plain multiply correct for both signednesses.
    assign w_fast_a     = w_op_signed ? {{WIDTH{i_rs[WIDTH-1]}}, i_rs} : {{WIDTH{1'b0}}, i_rs};
    assign w_fast_b     = w_op_signed ? {{WIDTH{i_rt[WIDTH-1]}}, i_rt} : {{WIDTH{1'b0}}, i_rt};
    assign w_fast_prod  = w_fast_a * w_fast_b;
    assign w_fast_wr    = w_accept && w_is_mul;
    assign w_iter_start = w_accept && w_is_div;
`else
    assign w_fast_prod  = '0;
    assign w_fast_wr    = 1'b0;
    assign w_iter_start = w_accept && (w_is_mul || w_is_div);
`endif

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_rs_back;

    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_prod      = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_quot      = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem       = r_neg_r ? -r_acc_hi : r_acc_hi;
    // Divide by zero returns the original dividend, rebuilt from its magnitude and sign.
    assign w_rs_back   = r_neg_r ? -r_a : r_a;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && i_op == OP_MTHI) begin
                        r_hi   <= i_rs;
                        r_done <= 1'b1;
                    end else if (w_accept && i_op == OP_MTLO) begin
                        r_lo   <= i_rs;
                        r_done <= 1'b1;
                    end else if (w_fast_wr) begin
                        {r_hi, r_lo} <= w_fast_prod;
                        r_done       <= 1'b1;
                    end else if (w_iter_start) begin
                        r_a      <= w_rs_mag;
                        r_b      <= w_rt_mag;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_is_div ? w_rs_mag : w_rt_mag;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
                        r_cnt    <= '0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
                            r_acc_hi <= w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0]
                                                          : w_div_diff[WIDTH-1:0];
                        end else begin
                            {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!i_abort) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod;
                        end else if (r_b == '0) begin
                            r_hi <= w_rs_back;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == S_CALC) || (r_state == S_FIX);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32), one task per scenario.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_op    (op),
        .i_rs    (rs),
        .i_rt    (rt),
        .i_abort (abort),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one START and return in the cycle where DONE is high (edges counted from accept).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output bit busy_seen);
        op = o; rs = a; rt = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        busy_seen = busy;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_seen = 1'b1;
        end
        $display("[TB] op=%0d rs=%h rt=%h -> hi=%h lo=%h edges=%0d busy_seen=%0d",
                 o, a, b, hi, lo, edges, busy_seen);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; op = 3'd0; rs = '0; rt = '0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_tests++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");
    endtask

    task automatic test_mult();
        logic [2:0]  t_op [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        logic [31:0] t_rs [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 32'h00000007};
        logic [31:0] t_rt [5] = '{32'h00000003, 32'h00000003, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic [31:0] t_hi [5] = '{32'hFFFFFFFF, 32'h00000002, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] t_lo [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'h00000000, 32'h00000001, 32'hFFFFFFDD};
        int  edges;
        bit  bsy;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_rs[i], t_rt[i], edges, bsy);
            n_tests++; if (hi !== t_hi[i]) begin n_fail++; $display("FAIL mult%0d_hi got %h want %h", i, hi, t_hi[i]); end
            n_tests++; if (lo !== t_lo[i]) begin n_fail++; $display("FAIL mult%0d_lo got %h want %h", i, lo, t_lo[i]); end
            n_tests++; if (edges != MUL_LAT) begin n_fail++; $display("FAIL mult%0d_latency got %0d want %0d", i, edges, MUL_LAT); end
            n_tests++; if (bsy != (MUL_LAT != 0)) begin n_fail++; $display("FAIL mult%0d_busy got %0d want %0d", i, bsy, MUL_LAT != 0); end
            @(posedge clk); #1;
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult%0d_done_pulse got %b want 0", i, done); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op [7] = '{3'd3, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2};
        logic [31:0] t_rs [7] = '{32'd100, 32'hFFFFFFF9, 32'd5, 32'h80000000, 32'd7, 32'hFFFFFFF0, 32'hFFFFFF9C};
        logic [31:0] t_rt [7] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFF9};
        logic [31:0] t_hi [7] = '{32'd2, 32'hFFFFFFFF, 32'd5, 32'h0, 32'd1, 32'hFFFFFFF0, 32'hFFFFFFFE};
        logic [31:0] t_lo [7] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
        int  edges;
        bit  bsy;
        for (int i = 0; i < 7; i++) begin
            run_op(t_op[i], t_rs[i], t_rt[i], edges, bsy);
            n_tests++; if (hi !== t_hi[i]) begin n_fail++; $display("FAIL div%0d_hi got %h want %h", i, hi, t_hi[i]); end
            n_tests++; if (lo !== t_lo[i]) begin n_fail++; $display("FAIL div%0d_lo got %h want %h", i, lo, t_lo[i]); end
            n_tests++; if (edges != DIV_LAT) begin n_fail++; $display("FAIL div%0d_latency got %0d want %0d", i, edges, DIV_LAT); end
            n_tests++; if (bsy != 1'b1) begin n_fail++; $display("FAIL div%0d_busy got %0d want 1", i, bsy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit bsy;
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, edges, bsy);
        // Still inside the DONE cycle: the next START must be accepted.
        run_op(3'd3, 32'd100, 32'd7, edges, bsy);
        n_tests++; if (edges != DIV_LAT) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", edges, DIV_LAT); end
        n_tests++; if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_lo got %h want 0000000e", lo); end
        n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi got %h want 00000002", hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int edges;
        bit bsy;
        int done_seen;
        run_op(3'd4, 32'hAAAA5555, 32'd0, edges, bsy);
        run_op(3'd5, 32'h0F0F0F0F, 32'd0, edges, bsy);
        @(posedge clk); #1;
        op = (MUL_LAT != 0) ? 3'd0 : 3'd3; rs = 32'd3; rt = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (c == 4) begin op = 3'd4; rs = 32'hDEADBEEF; start = 1'b1; end
            if (c == 6) start = 1'b0;
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        n_tests++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL start_in_busy_hi got %h want aaaa5555", hi); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy got %b want 0", busy); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
        n_tests++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL abort_hi got %h want aaaa5555", hi); end
        n_tests++; if (lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL abort_lo got %h want 0f0f0f0f", lo); end
        $display("[TB] abort: hi=%h lo=%h done_pulses=%0d", hi, lo, done_seen);

        // ABORT and START together in IDLE: START is dropped.
        op = 3'd4; rs = 32'h0000BEEF; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_tests++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL abort_start_hi got %h want aaaa5555", hi); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_start_done got %b want 0", done); end

        // Reserved opcodes are ignored.
        op = 3'd6; rs = 32'h11111111; rt = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reserved_op busy=%b done=%b want 0 0", busy, done); end
        n_tests++; if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL reserved_hilo got %h/%h want aaaa5555/0f0f0f0f", hi, lo); end
        $display("[TB] reserved op: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_mt_and_reset_mid_op();
        int edges;
        bit bsy;
        run_op(3'd4, 32'h1234, 32'd0, edges, bsy);
        n_tests++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi got %h want 00001234", hi); end
        n_tests++; if (edges != 0 || bsy) begin n_fail++; $display("FAIL mthi_timing edges=%0d busy=%0d want 0 0", edges, bsy); end
        run_op(3'd5, 32'h5678, 32'd0, edges, bsy);
        n_tests++; if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_lo got %h want 00005678", lo); end
        n_tests++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mtlo_keeps_hi got %h want 00001234", hi); end
        n_tests++; if (edges != 0 || bsy) begin n_fail++; $display("FAIL mtlo_timing edges=%0d busy=%0d want 0 0", edges, bsy); end
        op = 3'd2; rs = 32'd100; rt = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_tests++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
        $display("[TB] reset mid-DIV: busy=%b hi=%h lo=%h", busy, hi, lo);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_tests++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_partial got %h/%h busy=%b want 0/0 0", hi, lo, busy); end
    endtask

`ifdef MULDIV_FAST_MUL_EN
    task automatic test_fast_mul();
        int edges;
        bit bsy;
        run_op(3'd0, 32'd6, 32'd7, edges, bsy);
        n_tests++; if (lo !== 32'd42 || hi !== 32'd0) begin n_fail++; $display("FAIL fast_mul got %h/%h want 0/2a", hi, lo); end
        n_tests++; if (edges != 0 || bsy) begin n_fail++; $display("FAIL fast_mul_timing edges=%0d busy=%0d want 0 0", edges, bsy); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_abort();
`ifdef MULDIV_FAST_MUL_EN
        test_fast_mul();
`endif
        test_mt_and_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are even and >= 4.
REQ-002 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 RST_N  in  1  reset, asynchronous assert and synchronous release; active-low.
REQ-004 START  in  1  request to begin operation OP; sampled only when BUSY=0.
REQ-005 OP  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
REQ-006 RS  in  WIDTH  first operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 RT  in  WIDTH  second operand: multiplier or divisor.
REQ-008 ABORT  in  1  pipeline flush; cancels any in-flight operation.
REQ-009 BUSY  out  1  high while a multiply or divide is in progress.
REQ-010 DONE  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-011 HI  out  WIDTH  architectural HI register.
REQ-012 LO  out  WIDTH  architectural LO register.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FIX; BUSY=1 exactly in CALC and FIX.
REQ-014 In IDLE, START=1 with OP 0-3 and ABORT=0 SHALL latch the operands, latch the signedness, take operand magnitudes for the signed ops, clear the iteration counter and enter CALC.
REQ-015 In IDLE, START=1 with OP 4 or 5 SHALL write RS to HI (OP 4) or to LO (OP 5) at that edge, leave the other register unchanged, assert no BUSY and pulse DONE in the next cycle.
REQ-016 START with a reserved OP SHALL be ignored: no state change, no DONE.
REQ-017 CALC SHALL perform one shift-add multiply step or one restoring-divide step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL apply sign correction, write HI/LO, return to IDLE and assert DONE in the following cycle.
REQ-019 Latency: HI/LO SHALL change at the (WIDTH+1)th edge after the accept edge (33 edges for WIDTH=32).
REQ-020 Multiply SHALL produce a 2*WIDTH-bit product: HI gets the upper half, LO the lower half; MULT is signed two's complement, MULTU is unsigned.
REQ-021 Divide: LO gets the quotient and HI the remainder.
REQ-022 DIV quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 Divide by zero SHALL write LO to all ones and HI to RS, for both DIV and DIVU.
REQ-024 DIV of the most-negative value by -1 SHALL write LO to the most-negative value and HI to 0.
REQ-025 START while BUSY=1 SHALL be ignored; a START in the DONE cycle (IDLE) SHALL be accepted.
REQ-026 ABORT=1 in CALC or FIX SHALL force IDLE at the next edge, leave HI/LO unchanged and assert no DONE.
REQ-027 ABORT and START in the same IDLE cycle: ABORT wins and START is dropped.
REQ-028 HI/LO SHALL be stable except at the write edges defined in REQ-015, REQ-018 and REQ-030.

Reset
REQ-029 RST_N=0 SHALL immediately force IDLE and set HI=0, LO=0, BUSY=0 and DONE=0, including mid-operation; no partial result shall be written.

Configuration
REQ-030 With macro MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL compute combinationally, write HI/LO at the accept edge, pulse DONE in the next cycle and never assert BUSY; DIV/DIVU are unchanged.
REQ-031 With MULDIV_FAST_MUL_EN undefined, all multiplies SHALL use the iterative path (REQ-017 to REQ-019).

Verification (WIDTH=32)
REQ-032 MULT RS=0xFFFFFFFE, RT=3 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFFA, one DONE pulse; repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 DIVU 100/7 -> LO=14, HI=2; DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 Start MULT, assert ABORT at cycle 10 -> IDLE next edge, HI/LO hold prior values, no DONE; START during BUSY is ignored.
REQ-036 MTHI 0x1234, then MTLO 0x5678 -> HI=0x1234, LO=0x5678, DONE each, BUSY never high; then drop RST_N mid-DIV -> HI=LO=0, BUSY=0 immediately.
REQ-037 With MULDIV_FAST_MUL_EN defined, MULT 6*7 -> LO=42 and HI=0 at the accept edge, DONE next cycle, BUSY never high.
